mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle RV32I control unit for the next-generation datapath.
- Replaces the single-cycle combinational decoder with a Moore FSM: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Sequences instruction and data memory through ready-based handshakes, latches decoded control fields, and traps on illegal encodings or memory timeouts.
- Sits between the instruction register/PC logic and the ALU, register file and data memory.

Parameters:
- EXTOP_W, 6, width of ext_op (immediate-extender select).
- ALUOP_W, 5, width of alu_op.
- MEM_TIMEOUT, 15, maximum wait cycles for imem_ready/dmem_ready before trapping (1..255).
- TO_W, 8, width of the timeout counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- instr  in  32  instruction-register contents, valid from DECODE onward.
- br_taken  in  1  comparator result for the current branch, valid in EXEC.
- imem_ready  in  1  instruction fetch complete.
- dmem_ready  in  1  data access complete.
- imem_req  out  1  fetch request.
- ir_write  out  1  load IR.
- pc_write  out  1  update PC.
- pc_sel  out  2  next PC: 00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1.
- reg_write  out  1  register-file write strobe.
- dmem_req  out  1  data request.
- dmem_we  out  1  data write when dmem_req=1.
- dm_type  out  3  access size/sign.
- ext_op  out  EXTOP_W  immediate format.
- alu_op  out  ALUOP_W  ALU function.
- alu_src_a  out  2  00 rs1, 01 PC, 10 zero.
- alu_src_b  out  1  0 rs2, 1 immediate.
- wd_sel  out  2  00 ALU, 01 memory, 10 PC+4.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  00 none, 01 illegal, 10 imem timeout, 11 dmem timeout.

Behaviour:
- Reset: state=FETCH, timeout counter=0, decode latches=0. All strobes, trap and trap_cause are 0. alu_op=ALUOp_add, ext_op=ITYPE, dm_type=word, all selects 00/0. A reset asserted in any state (including mid-MEM) aborts the cycle with no reg_write or pc_write that cycle.
- FETCH:
  - imem_req=1.
  - imem_ready=1: ir_write=1, go to DECODE, counter cleared.
  - imem_ready=0: counter increments. When the counter equals MEM_TIMEOUT with ready still low, go to TRAP with cause 10.
- DECODE (1 cycle):
  - Latch opclass, alu_op, ext_op, dm_type, selects from instr.
  - Supported opcodes: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode, or any of the following, goes to TRAP with cause 01: load funct3 in {011,110,111}; store funct3 > 010; branch funct3 in {010,011}; funct7 not in {0000000,0100000}; 0100000 used with an illegal funct3.
  - Shift-immediate selects ext_op ITYPE_SHAMT.
- EXEC (1 cycle). Control outputs are driven from the latched fields.
  - BRANCH: pc_write=1, pc_sel=01 if br_taken else 00, then FETCH.
  - LOAD/STORE: go to MEM (address = rs1+imm, alu_op add, alu_src_b=1).
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE; dm_type held stable.
  - dmem_ready: LOAD goes to WB; STORE sets pc_write=1, pc_sel=00, then FETCH.
  - Timeout is handled as in FETCH, with cause 11.
- WB (1 cycle):
  - reg_write=1 and pc_write=1.
  - pc_sel: 01 for JAL, 10 for JALR, else 00.
  - wd_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - LUI uses alu_src_a=10; AUIPC uses alu_src_a=01.
- TRAP: all strobes 0, trap=1, trap_cause held; exits only on rst.
- dm_type encodings: word 000, half 001, half_u 010, byte 011, byte_u 100. These encodings must be distinct.
- CPI: 4 cycles for ALU/jump, 3 for branch, 4 for store, 5 for load, with zero-wait memory.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode constants;
  - EXT_CTRL_* and ALUOp_* constants;
  - dm_* encodings;
  - pc_sel/wd_sel/alu_src encodings;
  - FSM state enum;
  - trap cause codes.
- One sub-module, rv_decode, maps instr to control fields plus an illegal flag. It is purely combinational and registered by mc_ctrl in DECODE.

Test Plan:
- add x3,x1,x2 (0x002081B3), ready immediately:
  - reg_write=1 exactly in cycle 4 after fetch start;
  - alu_op=ALUOp_add, wd_sel=00, pc_sel=00.
- lw x3,0(x1) (0x0000A183), dmem_ready delayed 3 cycles:
  - dmem_req high 4 cycles with dm_type=000, dmem_we=0;
  - then WB with wd_sel=01.
- beq x1,x2,8 (0x00208463), tested with br_taken=1 and then br_taken=0:
  - pc_write pulse in EXEC with pc_sel=01 or 00 respectively;
  - reg_write never asserted.
- Instruction 0xFFFFFFFF:
  - trap=1, trap_cause=01 the cycle after DECODE;
  - stays set through 10 idle cycles until rst.
- imem_ready held low with MEM_TIMEOUT=15: trap_cause=10 after exactly 15 wait cycles.
- rst asserted during MEM of a store (0x0020A023):
  - next cycle state=FETCH with all strobes 0;
  - no pc_write observed.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, control-field
// constants, FSM states and the latched control record.
package rv_ctrl_pkg;

    localparam int EXT_W = 6;
    localparam int ALU_W = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [EXT_W-1:0] EXT_CTRL_ITYPE       = 6'd0;
    localparam logic [EXT_W-1:0] EXT_CTRL_ITYPE_SHAMT = 6'd1;
    localparam logic [EXT_W-1:0] EXT_CTRL_STYPE       = 6'd2;
    localparam logic [EXT_W-1:0] EXT_CTRL_BTYPE       = 6'd3;
    localparam logic [EXT_W-1:0] EXT_CTRL_UTYPE       = 6'd4;
    localparam logic [EXT_W-1:0] EXT_CTRL_JTYPE       = 6'd5;

    localparam logic [ALU_W-1:0] ALUOp_add  = 5'd0;
    localparam logic [ALU_W-1:0] ALUOp_sub  = 5'd1;
    localparam logic [ALU_W-1:0] ALUOp_sll  = 5'd2;
    localparam logic [ALU_W-1:0] ALUOp_slt  = 5'd3;
    localparam logic [ALU_W-1:0] ALUOp_sltu = 5'd4;
    localparam logic [ALU_W-1:0] ALUOp_xor  = 5'd5;
    localparam logic [ALU_W-1:0] ALUOp_srl  = 5'd6;
    localparam logic [ALU_W-1:0] ALUOp_sra  = 5'd7;
    localparam logic [ALU_W-1:0] ALUOp_or   = 5'd8;
    localparam logic [ALU_W-1:0] ALUOp_and  = 5'd9;

    localparam logic [2:0] dm_word   = 3'b000;
    localparam logic [2:0] dm_half   = 3'b001;
    localparam logic [2:0] dm_half_u = 3'b010;
    localparam logic [2:0] dm_byte   = 3'b011;
    localparam logic [2:0] dm_byte_u = 3'b100;

    localparam logic [1:0] PC_SEL_PC4  = 2'b00;
    localparam logic [1:0] PC_SEL_IMM  = 2'b01;
    localparam logic [1:0] PC_SEL_REG  = 2'b10;
    localparam logic [1:0] WD_SEL_ALU  = 2'b00;
    localparam logic [1:0] WD_SEL_MEM  = 2'b01;
    localparam logic [1:0] WD_SEL_PC4  = 2'b10;
    localparam logic [1:0] ASRC_A_RS1  = 2'b00;
    localparam logic [1:0] ASRC_A_PC   = 2'b01;
    localparam logic [1:0] ASRC_A_ZERO = 2'b10;
    localparam logic       ASRC_B_RS2  = 1'b0;
    localparam logic       ASRC_B_IMM  = 1'b1;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM_TO = 2'b10;
    localparam logic [1:0] TRAP_DMEM_TO = 2'b11;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;

    typedef enum logic [3:0] {
        OC_R, OC_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC
    } opclass_e;

    typedef struct packed {
        opclass_e         cls;
        logic [EXT_W-1:0] ext;
        logic [ALU_W-1:0] alu;
        logic [2:0]       dm;
        logic [1:0]       src_a;
        logic             src_b;
        logic [1:0]       wd;
        logic [1:0]       pcs;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        cls: OC_R, ext: EXT_CTRL_ITYPE, alu: ALUOp_add, dm: dm_word,
        src_a: ASRC_A_RS1, src_b: ASRC_B_RS2, wd: WD_SEL_ALU, pcs: PC_SEL_PC4
    };

    // alt selects the funct7[5] variant (sub/sra) where the encoding allows it.
    function automatic logic [ALU_W-1:0] alu_fn(input logic [2:0] f3, input logic alt);
        logic [ALU_W-1:0] op;
        case (f3)
            3'b000:  op = alt ? ALUOp_sub : ALUOp_add;
            3'b001:  op = ALUOp_sll;
            3'b010:  op = ALUOp_slt;
            3'b011:  op = ALUOp_sltu;
            3'b100:  op = ALUOp_xor;
            3'b101:  op = alt ? ALUOp_sra : ALUOp_srl;
            3'b110:  op = ALUOp_or;
            default: op = ALUOp_and;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_decode.sv
// Combinational RV32I decoder: instruction word to control record plus an
// illegal-encoding flag. Registered by mc_ctrl in its DECODE state.
module rv_decode
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_base;
    logic       f7_alt;
    logic       unused_fields;

    assign opcode        = instr_i[6:0];
    assign f3            = instr_i[14:12];
    assign f7            = instr_i[31:25];
    assign f7_base       = (f7 == 7'b0000000);
    assign f7_alt        = (f7 == 7'b0100000);
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl_o    = CTRL_RESET;
        illegal_o = 1'b0;
        case (opcode)
            OPC_R: begin
                ctrl_o.cls = OC_R;
                ctrl_o.alu = alu_fn(f3, instr_i[30]);
                illegal_o  = !(f7_base || (f7_alt && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_I: begin
                ctrl_o.cls   = OC_I;
                ctrl_o.src_b = ASRC_B_IMM;
                // Only shifts carry a funct7; elsewhere those bits are immediate.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    ctrl_o.ext = EXT_CTRL_ITYPE_SHAMT;
                    ctrl_o.alu = alu_fn(f3, f3[2] & instr_i[30]);
                    illegal_o  = !(f7_base || (f7_alt && f3 == 3'b101));
                end else begin
                    ctrl_o.alu = alu_fn(f3, 1'b0);
                end
            end
            OPC_LOAD: begin
                ctrl_o.cls   = OC_LOAD;
                ctrl_o.src_b = ASRC_B_IMM;
                ctrl_o.wd    = WD_SEL_MEM;
                case (f3)
                    3'b000:  ctrl_o.dm = dm_byte;
                    3'b001:  ctrl_o.dm = dm_half;
                    3'b010:  ctrl_o.dm = dm_word;
                    3'b100:  ctrl_o.dm = dm_byte_u;
                    3'b101:  ctrl_o.dm = dm_half_u;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl_o.cls   = OC_STORE;
                ctrl_o.ext   = EXT_CTRL_STYPE;
                ctrl_o.src_b = ASRC_B_IMM;
                case (f3)
                    3'b000:  ctrl_o.dm = dm_byte;
                    3'b001:  ctrl_o.dm = dm_half;
                    3'b010:  ctrl_o.dm = dm_word;
                    default: illegal_o = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                ctrl_o.cls = OC_BRANCH;
                ctrl_o.ext = EXT_CTRL_BTYPE;
                ctrl_o.alu = ALUOp_sub;
                illegal_o  = (f3 == 3'b010 || f3 == 3'b011);
            end
            OPC_JAL: begin
                ctrl_o.cls   = OC_JAL;
                ctrl_o.ext   = EXT_CTRL_JTYPE;
                ctrl_o.src_a = ASRC_A_PC;
                ctrl_o.src_b = ASRC_B_IMM;
                ctrl_o.wd    = WD_SEL_PC4;
                ctrl_o.pcs   = PC_SEL_IMM;
            end
            OPC_JALR: begin
                ctrl_o.cls   = OC_JALR;
                ctrl_o.src_b = ASRC_B_IMM;
                ctrl_o.wd    = WD_SEL_PC4;
                ctrl_o.pcs   = PC_SEL_REG;
            end
            OPC_LUI: begin
                ctrl_o.cls   = OC_LUI;
                ctrl_o.ext   = EXT_CTRL_UTYPE;
                ctrl_o.src_a = ASRC_A_ZERO;
                ctrl_o.src_b = ASRC_B_IMM;
            end
            OPC_AUIPC: begin
                ctrl_o.cls   = OC_AUIPC;
                ctrl_o.ext   = EXT_CTRL_UTYPE;
                ctrl_o.src_a = ASRC_A_PC;
                ctrl_o.src_b = ASRC_B_IMM;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// write-back, holding decoded fields stable and trapping on faults until reset.
module mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int EXTOP_W     = 6,
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               br_taken,
    input  logic               imem_ready,
    input  logic               dmem_ready,
    output logic               imem_req,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_sel,
    output logic               reg_write,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [2:0]         dm_type,
    output logic [EXTOP_W-1:0] ext_op,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         alu_src_a,
    output logic               alu_src_b,
    output logic [1:0]         wd_sel,
    output logic               trap,
    output logic [1:0]         trap_cause
);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    ctrl_t           ctrl_q, ctrl_d, dec_ctrl;
    logic [1:0]      cause_q, cause_d;
    logic            dec_illegal;
    logic            timeout;
    logic            imem_req_c, ir_write_c, pc_write_c, reg_write_c, dmem_req_c, dmem_we_c;
    logic [1:0]      pc_sel_c;

    rv_decode u_decode (
        .instr_i   (instr),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_illegal)
    );

    assign cnt_inc = cnt_q + TO_W'(1);
    assign timeout = (cnt_inc == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ctrl_q  <= CTRL_RESET;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        cause_d     = cause_q;
        imem_req_c  = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_sel_c    = PC_SEL_PC4;
        reg_write_c = 1'b0;
        dmem_req_c  = 1'b0;
        dmem_we_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_write_c = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DECODE;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        cause_d = TRAP_IMEM_TO;
                        state_d = S_TRAP;
                    end
                end
            end
            S_DECODE: begin
                // Illegal encodings leave the previous latched fields untouched.
                if (dec_illegal) begin
                    cause_d = TRAP_ILLEGAL;
                    state_d = S_TRAP;
                end else begin
                    ctrl_d  = dec_ctrl;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = '0;
                case (ctrl_q.cls)
                    OC_BRANCH: begin
                        pc_write_c = 1'b1;
                        pc_sel_c   = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
                        state_d    = S_FETCH;
                    end
                    OC_LOAD, OC_STORE: state_d = S_MEM;
                    default:           state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (ctrl_q.cls == OC_STORE);
                if (dmem_ready) begin
                    cnt_d = '0;
                    if (ctrl_q.cls == OC_STORE) begin
                        pc_write_c = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout) begin
                        cause_d = TRAP_DMEM_TO;
                        state_d = S_TRAP;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                pc_write_c  = 1'b1;
                pc_sel_c    = ctrl_q.pcs;
                state_d     = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every strobe in its own cycle so an aborted access never commits.
    assign imem_req   = imem_req_c  & ~rst;
    assign ir_write   = ir_write_c  & ~rst;
    assign pc_write   = pc_write_c  & ~rst;
    assign reg_write  = reg_write_c & ~rst;
    assign dmem_req   = dmem_req_c  & ~rst;
    assign dmem_we    = dmem_we_c   & ~rst;
    assign pc_sel     = rst ? PC_SEL_PC4 : pc_sel_c;

    assign dm_type    = ctrl_q.dm;
    assign ext_op     = EXTOP_W'(ctrl_q.ext);
    assign alu_op     = ALUOP_W'(ctrl_q.alu);
    assign alu_src_a  = ctrl_q.src_a;
    assign alu_src_b  = ctrl_q.src_b;
    assign wd_sel     = ctrl_q.wd;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;

endmodule
